// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_LD  = 1'b0,
    OWN_CPU = 1'b1
  } arb_owner_e;

  localparam int ACCESS_CYCLES_DEF = 2;
  localparam int TMR_W             = 4;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter with a zero flag; it counts the cycles of one RAM access.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between the boot loader and the core.
// Define MEM_ARBITER_ALIGN_CHECK_EN to fault misaligned core accesses instead of forcing alignment.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  input  logic              boot_done,
  output logic              cpu_run,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe
);

  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(ACCESS_CYCLES - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              boot_q, boot_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              unused_lsb;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  logic              fault_q, fault_d;
`endif

  mem_arb_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TMR_INIT),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    boot_d   = boot_q | boot_done;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    fault_d  = fault_q;
`endif
    case (state_q)
      IDLE: begin
        // Loader always wins; the core waits until the sticky boot flag is set.
        if (ld_req) begin
          owner_d  = OWN_LD;
          addr_d   = {ld_addr[ADDR_W-1:2], 2'b00};
          wdata_d  = ld_wdata;
          we_d     = 1'b1;
          tmr_load = 1'b1;
          state_d  = ACCESS;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
          fault_d  = 1'b0;
`endif
        end else if (cpu_req && boot_q) begin
          owner_d  = OWN_CPU;
          addr_d   = {cpu_addr[ADDR_W-1:2], 2'b00};
          wdata_d  = cpu_wdata;
          we_d     = cpu_we;
          tmr_load = 1'b1;
          state_d  = ACCESS;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
          fault_d  = 1'b0;
          if (cpu_addr[1:0] != 2'b00) begin
            // Misaligned: skip the RAM entirely and answer with a fault.
            fault_d  = 1'b1;
            addr_d   = addr_q;
            wdata_d  = wdata_q;
            we_d     = 1'b0;
            tmr_load = 1'b0;
            state_d  = RESP;
          end
`endif
        end
      end
      ACCESS: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_d = RESP;
          // Latch read data on the last access cycle so it is valid alongside the ack.
          if ((owner_q == OWN_CPU) && !we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_LD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      boot_q  <= 1'b0;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      boot_q  <= boot_d;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign mem_cs    = (state_q == ACCESS);
  assign mem_we    = mem_cs && we_q;
  assign mem_oe    = mem_cs && !we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ld_ack    = (state_q == RESP) && (owner_q == OWN_LD);
  assign cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);
  assign cpu_rdata = rdata_q;
  assign cpu_run   = boot_q && (state_q == IDLE);

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  assign cpu_fault  = cpu_ack && fault_q;
  assign unused_lsb = ^ld_addr[1:0];
`else
  assign cpu_fault  = 1'b0;
  assign unused_lsb = ^{ld_addr[1:0], cpu_addr[1:0]};
`endif

endmodule
